// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : score_sequencer
// Purpose  : Plays a stored two-channel score through the square-wave note
//            generator. Score words are fetched from an external synchronous
//            ROM. Each entry drives the left/right divider outputs for
//            dur * beat_cycles clock cycles. The last GAP_CYCLES cycles of
//            every entry are muted so that repeated notes stay articulated.
//            The block also provides play/pause/stop transport, optional
//            looping and a saturating volume control.
//
// Ports    : clk            system clock
//            rst            asynchronous, active-low reset
//            play           pulse: start from IDLE / resume from PAUSED
//            pause          pulse: pause while playing
//            stop           pulse: abort and return to IDLE
//            loop_en        level: restart at address 0 on the end marker
//            vol_up         pulse: volume + 1 (saturates at 5)
//            vol_down       pulse: volume - 1 (saturates at 0)
//            beat_cycles    clock cycles per beat (0 is treated as 1)
//            rom_addr       score ROM address (data valid one cycle later)
//            rom_data       score word {dur[3:0], div_left[21:0], div_right[21:0]}
//            note_div_left  left-channel divider (1 = rest)
//            note_div_right right-channel divider (1 = rest)
//            vol            volume 0..5
//            playing        high in FETCH, LOAD and PLAY
//            song_end       one-cycle pulse when the score ends without looping
//
// Revision : 1.0 - initial release
// ============================================================================

module score_sequencer #(
   parameter int          ADDR_W     = 8,
   parameter logic [15:0] GAP_CYCLES = 16'd2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic              vol_up,
   input  logic              vol_down,
   input  logic [23:0]       beat_cycles,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [47:0]       rom_data,
   output logic [21:0]       note_div_left,
   output logic [21:0]       note_div_right,
   output logic [2:0]        vol,
   output logic              playing,
   output logic              song_end
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [21:0] C_DIV_REST = 22'd1;
   localparam logic [23:0] C_GAP      = 24'(GAP_CYCLES);
   localparam logic [2:0]  C_VOL_MAX  = 3'd5;
   localparam logic [2:0]  C_VOL_RST  = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_PLAY   = 3'd3,
      S_PAUSED = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // State and latched entry data
   // -------------------------------------------------------------------------
   state_t      r_state;
   logic [23:0] r_beat_cnt;
   logic [3:0]  r_beats_left;
   logic [23:0] r_beat_lat;
   logic [21:0] r_div_left;
   logic [21:0] r_div_right;

   // -------------------------------------------------------------------------
   // Mute window: the tail of the final beat of an entry. When the beat is
   // no longer than the gap, the whole final beat is silent.
   // -------------------------------------------------------------------------
   function automatic logic f_mute(input logic [3:0]  bl,
                                   input logic [23:0] cnt,
                                   input logic [23:0] lat);
      f_mute = (bl == 4'd1) && ((lat <= C_GAP) || (cnt >= (lat - C_GAP)));
   endfunction

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic [3:0]  w_rom_dur;
   logic [21:0] w_rom_div_left;
   logic [21:0] w_rom_div_right;
   logic [23:0] w_load_lat;
   logic        w_last_tick;
   logic        w_entry_done;
   logic [23:0] w_cnt_adv;
   logic [3:0]  w_bl_adv;
   logic        w_load_mute;
   logic        w_play_mute;
   logic        w_resume_mute;
   logic        w_vol_inc;
   logic        w_vol_dec;

   assign w_rom_dur       = rom_data[47:44];
   assign w_rom_div_left  = rom_data[43:22];
   assign w_rom_div_right = rom_data[21:0];

   // A tempo of zero would never complete a beat, so it is clamped to one.
   assign w_load_lat = (beat_cycles == 24'd0) ? 24'd1 : beat_cycles;

   // Beat counter advance used by PLAY. A pause pulse still lets the current
   // PLAY cycle count, so a pause/resume pair loses no playback cycles.
   assign w_last_tick  = (r_beat_cnt == (r_beat_lat - 24'd1));
   assign w_entry_done = w_last_tick && (r_beats_left == 4'd1);
   assign w_cnt_adv    = w_last_tick ? 24'd0 : (r_beat_cnt + 24'd1);
   assign w_bl_adv     = w_last_tick ? (r_beats_left - 4'd1) : r_beats_left;

   // Mute is evaluated on the counter values the next cycle will hold,
   // because the divider outputs are registered alongside the state.
   assign w_load_mute   = f_mute(w_rom_dur, 24'd0, w_load_lat);
   assign w_play_mute   = f_mute(w_bl_adv, w_cnt_adv, r_beat_lat);
   assign w_resume_mute = f_mute(r_beats_left, r_beat_cnt, r_beat_lat);

   // Simultaneous up/down cancel out.
   assign w_vol_inc = vol_up && !vol_down && (vol != C_VOL_MAX);
   assign w_vol_dec = vol_down && !vol_up && (vol != 3'd0);

   // -------------------------------------------------------------------------
   // Transport state machine with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         rom_addr       <= '0;
         r_beat_cnt     <= 24'd0;
         r_beats_left   <= 4'd0;
         r_beat_lat     <= 24'd1;
         r_div_left     <= C_DIV_REST;
         r_div_right    <= C_DIV_REST;
         note_div_left  <= C_DIV_REST;
         note_div_right <= C_DIV_REST;
         playing        <= 1'b0;
         song_end       <= 1'b0;
      end else begin
         song_end <= 1'b0;

         if (stop) begin
            // Abort has top priority from every state and never flags an end.
            r_state        <= S_IDLE;
            rom_addr       <= '0;
            r_beat_cnt     <= 24'd0;
            r_beats_left   <= 4'd0;
            note_div_left  <= C_DIV_REST;
            note_div_right <= C_DIV_REST;
            playing        <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  note_div_left  <= C_DIV_REST;
                  note_div_right <= C_DIV_REST;
                  playing        <= 1'b0;
                  // pause outranks play, so a coincident pause blocks the start
                  if (play && !pause) begin
                     r_state <= S_FETCH;
                     playing <= 1'b1;
                  end
               end

               S_FETCH: begin
                  // rom_addr is held here; the ROM word is valid in LOAD.
                  r_state        <= S_LOAD;
                  note_div_left  <= C_DIV_REST;
                  note_div_right <= C_DIV_REST;
                  playing        <= 1'b1;
               end

               S_LOAD: begin
                  if (w_rom_dur == 4'd0) begin
                     // End marker: rewind, then either loop or finish.
                     rom_addr       <= '0;
                     note_div_left  <= C_DIV_REST;
                     note_div_right <= C_DIV_REST;
                     if (loop_en) begin
                        r_state <= S_FETCH;
                        playing <= 1'b1;
                     end else begin
                        r_state  <= S_IDLE;
                        playing  <= 1'b0;
                        song_end <= 1'b1;
                     end
                  end else begin
                     r_div_left   <= w_rom_div_left;
                     r_div_right  <= w_rom_div_right;
                     r_beat_lat   <= w_load_lat;
                     r_beats_left <= w_rom_dur;
                     r_beat_cnt   <= 24'd0;
                     rom_addr     <= rom_addr + ADDR_W'(1);
                     r_state      <= S_PLAY;
                     playing      <= 1'b1;
                     // The first PLAY cycle already shows the new note.
                     note_div_left  <= w_load_mute ? C_DIV_REST : w_rom_div_left;
                     note_div_right <= w_load_mute ? C_DIV_REST : w_rom_div_right;
                  end
               end

               S_PLAY: begin
                  r_beat_cnt   <= w_cnt_adv;
                  r_beats_left <= w_bl_adv;
                  if (pause) begin
                     // If this was the entry's final cycle, beats_left is now
                     // zero and resuming goes straight on to the next fetch.
                     r_state        <= S_PAUSED;
                     note_div_left  <= C_DIV_REST;
                     note_div_right <= C_DIV_REST;
                     playing        <= 1'b0;
                  end else if (w_entry_done) begin
                     r_state        <= S_FETCH;
                     note_div_left  <= C_DIV_REST;
                     note_div_right <= C_DIV_REST;
                     playing        <= 1'b1;
                  end else begin
                     note_div_left  <= w_play_mute ? C_DIV_REST : r_div_left;
                     note_div_right <= w_play_mute ? C_DIV_REST : r_div_right;
                     playing        <= 1'b1;
                  end
               end

               S_PAUSED: begin
                  note_div_left  <= C_DIV_REST;
                  note_div_right <= C_DIV_REST;
                  playing        <= 1'b0;
                  if (play && !pause) begin
                     playing <= 1'b1;
                     if (r_beats_left == 4'd0) begin
                        r_state <= S_FETCH;
                     end else begin
                        r_state        <= S_PLAY;
                        note_div_left  <= w_resume_mute ? C_DIV_REST : r_div_left;
                        note_div_right <= w_resume_mute ? C_DIV_REST : r_div_right;
                     end
                  end
               end

               default: begin
                  r_state        <= S_IDLE;
                  rom_addr       <= '0;
                  r_beat_cnt     <= 24'd0;
                  r_beats_left   <= 4'd0;
                  note_div_left  <= C_DIV_REST;
                  note_div_right <= C_DIV_REST;
                  playing        <= 1'b0;
               end
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Volume: independent of transport state, untouched by stop
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vol <= C_VOL_RST;
      end else if (w_vol_inc) begin
         vol <= vol + 3'd1;
      end else if (w_vol_dec) begin
         vol <= vol - 3'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_sequencer
// Purpose  : Self-checking bench for score_sequencer. A behavioural ROM holds
//            a three-entry score; expected per-cycle output samples are queued
//            when a run is started and compared as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================

module tb_score_sequencer;

   localparam int ADDR_W = 8;
   localparam int GAP    = 2;
   localparam int LAT    = 10;

   logic              clk;
   logic              rst;
   logic              play;
   logic              pause;
   logic              stop;
   logic              loop_en;
   logic              vol_up;
   logic              vol_down;
   logic [23:0]       beat_cycles;
   logic [ADDR_W-1:0] rom_addr;
   logic [47:0]       rom_data;
   logic [21:0]       note_div_left;
   logic [21:0]       note_div_right;
   logic [2:0]        vol;
   logic              playing;
   logic              song_end;

   logic [47:0] rom_mem [0:255];
   logic [53:0] exp_q [$];
   int          n_total;
   int          n_pass;
   int          exp_vol;

   score_sequencer #(
      .ADDR_W     (ADDR_W),
      .GAP_CYCLES (16'd2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .play           (play),
      .pause          (pause),
      .stop           (stop),
      .loop_en        (loop_en),
      .vol_up         (vol_up),
      .vol_down       (vol_down),
      .beat_cycles    (beat_cycles),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .note_div_left  (note_div_left),
      .note_div_right (note_div_right),
      .vol            (vol),
      .playing        (playing),
      .song_end       (song_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for an address appears one cycle later.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [21:0] l, input logic [21:0] r,
                       input logic [7:0] a, input logic pl, input logic se);
      exp_q.push_back({l, r, a, pl, se});
   endtask

   // FETCH, LOAD, then dur*lat PLAY samples; optional pause window after
   // PLAY sample pause_idx. Mute is derived from the position in the entry.
   task automatic push_entry(input logic [7:0] a, input logic [21:0] l, input logic [21:0] r,
                             input int dur, input int lat, input int pause_idx, input int pause_len);
      int total;
      int mute_from;
      logic [7:0] an;
      an = a + 8'd1;
      push(22'd1, 22'd1, a, 1'b1, 1'b0);
      push(22'd1, 22'd1, a, 1'b1, 1'b0);
      total     = dur * lat;
      mute_from = (dur - 1) * lat + ((lat > GAP) ? (lat - GAP) : 0);
      for (int i = 0; i < total; i++) begin
         if (i >= mute_from) push(22'd1, 22'd1, an, 1'b1, 1'b0);
         else                push(l, r, an, 1'b1, 1'b0);
         if (i == pause_idx)
            for (int k = 0; k < pause_len; k++) push(22'd1, 22'd1, an, 1'b0, 1'b0);
      end
   endtask

   task automatic push_marker_end();
      push(22'd1, 22'd1, 8'd2, 1'b1, 1'b0);   // FETCH of marker
      push(22'd1, 22'd1, 8'd2, 1'b1, 1'b0);   // LOAD of marker
      push(22'd1, 22'd1, 8'd0, 1'b0, 1'b1);   // IDLE, song_end pulse
      push(22'd1, 22'd1, 8'd0, 1'b0, 1'b0);   // IDLE, pulse gone
   endtask

   // Start with a play pulse, then compare one queued sample per cycle while
   // driving the scheduled commands at the given sample numbers.
   task automatic run(input string tag, input int pause_at, input int both_at,
                      input int resume_at, input int clr_loop_at, input int stop_at);
      int n;
      logic [53:0] e;
      play = 1'b1;
      tick();
      play = 1'b0;
      n = 1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s n=%0d", tag, n),
               {10'd0, note_div_left, note_div_right, rom_addr, playing, song_end},
               {10'd0, e});
         pause = (n == pause_at) || (n == both_at) || (n == stop_at);
         play  = (n == resume_at) || (n == both_at);
         stop  = (n == stop_at);
         if (n == clr_loop_at) loop_en = 1'b0;
         tick();
         n++;
      end
      play  = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic vol_pulse(input logic up, input logic dn);
      vol_up   = up;
      vol_down = dn;
      if (up && !dn && exp_vol < 5) exp_vol++;
      if (dn && !up && exp_vol > 0) exp_vol--;
      tick();
      vol_up   = 1'b0;
      vol_down = 1'b0;
      check("vol", 64'(vol), 64'(exp_vol));
   endtask

   initial begin
      n_total     = 0;
      n_pass      = 0;
      rst         = 1'b0;
      play        = 1'b0;
      pause       = 1'b0;
      stop        = 1'b0;
      loop_en     = 1'b0;
      vol_up      = 1'b0;
      vol_down    = 1'b0;
      beat_cycles = 24'(LAT);
      for (int i = 0; i < 256; i++) rom_mem[i] = 48'd0;
      rom_mem[0] = {4'd2, 22'd100, 22'd200};
      rom_mem[1] = {4'd1, 22'd300, 22'd400};
      rom_mem[2] = {4'd0, 22'd7,   22'd9};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_div_l",   64'(note_div_left),  64'd1);
      check("rst_div_r",   64'(note_div_right), 64'd1);
      check("rst_vol",     64'(vol),            64'd3);
      check("rst_addr",    64'(rom_addr),       64'd0);
      check("rst_playing", 64'(playing),        64'd0);
      check("rst_song_end",64'(song_end),       64'd0);
      rst = 1'b1;
      tick();

      // Volume saturation and cancel
      exp_vol = 3;
      repeat (3) vol_pulse(1'b1, 1'b0);
      repeat (6) vol_pulse(1'b0, 1'b1);
      repeat (2) vol_pulse(1'b1, 1'b0);
      vol_pulse(1'b1, 1'b1);

      // Basic score
      push_entry(8'd0, 22'd100, 22'd200, 2, LAT, -1, 0);
      push_entry(8'd1, 22'd300, 22'd400, 1, LAT, -1, 0);
      push_marker_end();
      run("basic", -1, -1, -1, -1, -1);

      // Pause at PLAY sample 4 (n=7) for 50 cycles; play+pause at n=30 is held off
      push_entry(8'd0, 22'd100, 22'd200, 2, LAT, 4, 50);
      push_entry(8'd1, 22'd300, 22'd400, 1, LAT, -1, 0);
      push_marker_end();
      run("pause", 7, 30, 57, -1, -1);

      // Loop once, clear loop_en during the replay of entry 0
      loop_en = 1'b1;
      push_entry(8'd0, 22'd100, 22'd200, 2, LAT, -1, 0);
      push_entry(8'd1, 22'd300, 22'd400, 1, LAT, -1, 0);
      push(22'd1, 22'd1, 8'd2, 1'b1, 1'b0);
      push(22'd1, 22'd1, 8'd2, 1'b1, 1'b0);
      push_entry(8'd0, 22'd100, 22'd200, 2, LAT, -1, 0);
      push_entry(8'd1, 22'd300, 22'd400, 1, LAT, -1, 0);
      push_marker_end();
      run("loop", -1, -1, -1, 50, -1);

      // stop + pause together in PLAY sample 7 (n=10)
      push(22'd1, 22'd1, 8'd0, 1'b1, 1'b0);
      push(22'd1, 22'd1, 8'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) push(22'd100, 22'd200, 8'd1, 1'b1, 1'b0);
      repeat (3) push(22'd1, 22'd1, 8'd0, 1'b0, 1'b0);
      run("stop", -1, -1, -1, -1, 10);
      check("vol_after_stop", 64'(vol), 64'(exp_vol));

      // Asynchronous reset in the middle of PLAY
      vol_pulse(1'b1, 1'b0);
      vol_pulse(1'b1, 1'b0);
      play = 1'b1;
      tick();
      play = 1'b0;
      repeat (4) tick();
      check("pre_rst_div_l", 64'(note_div_left), 64'd100);
      rst = 1'b0;
      #1;
      check("arst_div_l",   64'(note_div_left),  64'd1);
      check("arst_div_r",   64'(note_div_right), 64'd1);
      check("arst_vol",     64'(vol),            64'd3);
      check("arst_addr",    64'(rom_addr),       64'd0);
      check("arst_playing", 64'(playing),        64'd0);
      tick();
      rst = 1'b1;
      repeat (4) tick();
      check("post_rst_playing", 64'(playing),       64'd0);
      check("post_rst_div_l",   64'(note_div_left), 64'd1);
      check("post_rst_addr",    64'(rom_addr),      64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Plays a stored two-channel score through the square-wave note generator.
- Fetches score words from an external synchronous ROM and drives the note generator's left/right divider inputs for a timed duration per entry.
- Provides play/pause/stop transport, optional looping and a saturating volume control.
- Sits between the top-level control logic (buttons/FSM) and the note generator.

Parameters:
- ADDR_W, 8, score ROM address width; the score holds up to 2^ADDR_W entries.
- GAP_CYCLES, 16'd2, number of cycles muted at the end of each entry so that repeated notes are articulated.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- play  in  1  single-cycle pulse: start from IDLE, or resume from PAUSED
- pause  in  1  single-cycle pulse: pause while in PLAY
- stop  in  1  single-cycle pulse: abort and return to IDLE
- loop_en  in  1  level: restart at address 0 on the end marker
- vol_up  in  1  single-cycle pulse: increase volume
- vol_down  in  1  single-cycle pulse: decrease volume
- beat_cycles  in  24  clock cycles per beat (tempo)
- rom_addr  out  ADDR_W  score ROM address; ROM data is valid one cycle after the address
- rom_data  in  48  score word: [47:44] dur in beats, [43:22] div_left, [21:0] div_right; a div value of 1 means rest
- note_div_left  out  22  divider for the note generator's left channel
- note_div_right  out  22  divider for the note generator's right channel
- vol  out  3  volume 0..5 for the note generator
- playing  out  1  high in FETCH, LOAD and PLAY
- song_end  out  1  one-cycle pulse when the end marker is reached and loop_en=0

Behaviour:
Reset and outputs
- All outputs are registered.
- On rst=0, asynchronously: state=IDLE, rom_addr=0, note_div_left=note_div_right=1, vol=3, playing=0, song_end=0, beat_cnt=0, beats_left=0.

State machine (states: IDLE, FETCH, LOAD, PLAY, PAUSED)
- IDLE: divs=1. play -> FETCH.
- FETCH: one cycle; rom_addr is held; divs=1. Always -> LOAD.
- LOAD: samples rom_data.
  - If dur==0 (end marker) and loop_en=1: rom_addr<=0 -> FETCH.
  - If dur==0 and loop_en=0: song_end=1 for one cycle, rom_addr<=0 -> IDLE.
  - Otherwise: latch div_left, div_right and beat_cycles (a value of 0 is treated as 1). Set beats_left=dur, beat_cnt=0, rom_addr<=rom_addr+1 (wraps modulo 2^ADDR_W) -> PLAY.
- PLAY: beat_cnt counts 0..beat_lat-1.
  - At beat_lat-1: beat_cnt<=0 and beats_left decrements.
  - When beats_left==1 and beat_cnt==beat_lat-1: -> FETCH.
  - The entry therefore occupies exactly dur*beat_lat PLAY cycles, plus 2 overhead cycles (FETCH, LOAD) between entries.
- Outputs in PLAY:
  - note_div_left/right = latched divs.
  - Exception: they are 1 when beats_left==1 and beat_cnt >= beat_lat-GAP_CYCLES. If beat_lat <= GAP_CYCLES, the whole final beat is muted.
- Output register timing: values are updated on the same edge as the state, so the first PLAY cycle already shows the latched divs.
- PAUSED: counters and rom_addr are frozen; divs=1; playing=0. play -> PLAY, continuing at the frozen count with no lost cycles.

Priority and ignored events
- Command priority: stop > pause > play.
- stop from any state: -> IDLE next cycle, rom_addr=0, counters=0, divs=1, no song_end pulse.
- pause outside PLAY is ignored. play in FETCH, LOAD or PLAY is ignored.
- A beat_cycles change during PLAY takes effect at the next LOAD.

Volume (independent of state)
- vol_up increments vol, saturating at 5.
- vol_down decrements vol, saturating at 0.
- Both asserted in the same cycle: no change.
- stop does not affect vol.

Test Plan:
- Reset: assert rst=0 mid-PLAY -> immediately divs=1, vol=3, rom_addr=0, playing=0; after release the block stays in IDLE.
- Basic score: ROM[0]={2,100,200}, ROM[1]={1,300,400}, ROM[2]={0,...}, beat_cycles=10, GAP=2, play pulse.
  - -> divs 100/200 for 18 cycles, then 1 for 2 cycles.
  - -> FETCH/LOAD with divs=1, then 300/400 for 8 cycles, then 1 for 2 cycles.
  - -> song_end pulses once, IDLE, rom_addr=0.
- Pause: pause at PLAY cycle 5 of ROM[0], hold 50 cycles, then play -> divs=1 and playing=0 while paused; ROM[0] still totals 20 PLAY cycles; ROM[1] starts 50 cycles later than without pause.
- Loop: same score with loop_en=1 -> no song_end; after ROM[2], FETCH at address 0 and ROM[0] replays; clearing loop_en before the marker ends the song normally.
- Priority: stop and pause in the same PLAY cycle -> IDLE, divs=1, rom_addr=0, no song_end. play and pause in the same PAUSED cycle -> remains PAUSED.
- Volume: 3 vol_up pulses from reset -> vol=5 (saturated). 6 vol_down pulses -> vol=0. vol_up and vol_down together -> unchanged.
